jt6295_accmix: RTL and testbench

- Parametrised voice mixer plus upsampler for the ADPCM output path.
- Sums a configurable number of time-multiplexed voice samples per output frame and narrows the sum to the output width.
- Produces RATE linearly interpolated output samples per frame, one per cen_out strobe.
- Sits between the voice channel datapath and the DAC/mixer interface; replaces the fixed 4-voice accumulator and CIC interpolator pair.

---
 rtl/jt6295_accmix.sv | 117 +++++++++++
 tb/tb_jt6295_accmix.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_accmix.sv
// jt6295_accmix: time-multiplexed voice accumulator plus linear-interpolating
// upsampler for the ADPCM output path.
// Optional build macro JT6295_ACCMIX_SAT_EN: saturate the frame sum to OW bits
// and report it on clip; otherwise the sum wraps and clip stays 0.
module jt6295_accmix #(
  parameter int IW        = 12,
  parameter int OW        = 14,
  parameter int VOICES    = 8,
  parameter int RATE_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 cen_slot,
  input  logic                 cen_out,
  input  logic signed [IW-1:0] sound_in,
  output logic signed [OW-1:0] sound_out,
  output logic                 sample,
  output logic                 clip,
  output logic                 slot_err
);

  localparam int AW   = IW + $clog2(VOICES) + 1;
  localparam int CW   = $clog2(VOICES + 1);
  localparam int RATE = 1 << RATE_LOG2;
  localparam int PW   = OW + RATE_LOG2 + 2;

  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic signed [OW-1:0]  prev, cur;
  logic [RATE_LOG2-1:0]  phase;

  logic signed [OW-1:0]  narrowed;
  logic                  sat;
  logic signed [OW:0]    diff;
  logic [RATE_LOG2:0]    step;
  logic signed [PW-1:0]  prod;
  logic signed [OW-1:0]  interp;

`ifdef JT6295_ACCMIX_SAT_EN
  localparam int NW = (AW > OW) ? AW : OW;
  localparam logic signed [NW-1:0] MAX_V = {{(NW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [NW-1:0] MIN_V = {{(NW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  logic signed [NW-1:0] acc_x;

  // Clamp the frame sum into the output range and flag when it had to.
  always_comb begin
    acc_x    = NW'(acc);
    narrowed = OW'(acc_x);
    sat      = 1'b0;
    if (acc_x > MAX_V) begin
      narrowed = OW'(MAX_V);
      sat      = 1'b1;
    end else if (acc_x < MIN_V) begin
      narrowed = OW'(MIN_V);
      sat      = 1'b1;
    end
  end
`else
  // Two's-complement wrap: keep the low OW bits, never report clipping.
  always_comb begin
    narrowed = OW'(acc);
    sat      = 1'b0;
  end
`endif

  // Next interpolated point: prev + (cur-prev)*(phase+1)/RATE, floored.
  always_comb begin
    diff   = (OW+1)'(cur) - (OW+1)'(prev);
    step   = {1'b0, phase} + (RATE_LOG2+1)'(1);
    prod   = PW'(diff) * PW'($signed({1'b0, step}));
    interp = prev + OW'(prod >>> RATE_LOG2);
  end

  // Voice accumulator; cen with a slot starts a fresh sum, excess slots are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      slot_err <= 1'b0;
    end else if (cen_slot) begin
      if (cen) begin
        acc <= AW'(sound_in);
        cnt <= CW'(1);
      end else if (cnt < CW'(VOICES)) begin
        acc <= acc + AW'(sound_in);
        cnt <= cnt + CW'(1);
      end else begin
        slot_err <= 1'b1;
      end
    end
  end

  // Frame latch and interpolator; cen wins the phase update over cen_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      cur       <= '0;
      clip      <= 1'b0;
      phase     <= '0;
      sound_out <= '0;
      sample    <= 1'b0;
    end else begin
      sample <= cen_out;
      if (cen_out) sound_out <= interp;
      if (cen) begin
        prev  <= cur;
        cur   <= narrowed;
        clip  <= sat;
        phase <= '0;
      end else if (cen_out && phase != RATE_LOG2'(RATE - 1)) begin
        phase <= phase + RATE_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_jt6295_accmix.sv
// Bench for jt6295_accmix: directed vector table, hand-written corner
// sequences, then random strobes against a frame-level reference model.
module tb_jt6295_accmix;

  localparam int IW = 12, OW = 14, VOICES = 8, RATE_LOG2 = 2;
  localparam int RATE = 1 << RATE_LOG2;
  localparam int HALF = 1 << (OW - 1);

  logic clk = 1'b0, rst = 1'b1;
  logic cen = 1'b0, cen_slot = 1'b0, cen_out = 1'b0;
  logic signed [IW-1:0] sound_in = '0;
  logic signed [OW-1:0] sound_out;
  logic sample, clip, slot_err;

  int pass_cnt = 0, tot_cnt = 0;

  jt6295_accmix #(.IW(IW), .OW(OW), .VOICES(VOICES), .RATE_LOG2(RATE_LOG2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cen_slot(cen_slot), .cen_out(cen_out),
    .sound_in(sound_in), .sound_out(sound_out), .sample(sample), .clip(clip),
    .slot_err(slot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tot_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s got %0d expected %0d", name, got, exp);
  endtask

  // One clock with the given strobes; outputs are stable #1 after the edge.
  task automatic cyc(input bit c, input bit s, input bit o, input int din);
    cen = c; cen_slot = s; cen_out = o; sound_in = IW'(din);
    @(posedge clk); #1;
    cen = 0; cen_slot = 0; cen_out = 0;
  endtask

  // Reference model, frame level.
  function automatic int narrow_m(input int x);
`ifdef JT6295_ACCMIX_SAT_EN
    if (x > HALF - 1) return HALF - 1;
    if (x < -HALF) return -HALF;
    return x;
`else
    return ((x + HALF) & (2 * HALF - 1)) - HALF;
`endif
  endfunction

  function automatic bit sat_m(input int x);
`ifdef JT6295_ACCMIX_SAT_EN
    return (x > HALF - 1) || (x < -HALF);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int floor_div(input int x, input int r);
    return (x - (((x % r) + r) % r)) / r;
  endfunction

  int m_q[$];
  int m_prev, m_cur, m_phase, m_out;
  bit m_clip, m_err, m_sample;

  task automatic model_reset();
    m_q.delete();
    m_prev = 0; m_cur = 0; m_phase = 0; m_out = 0;
    m_clip = 0; m_err = 0; m_sample = 0;
  endtask

  task automatic model_step(input bit c, input bit s, input bit o, input int din);
    int sum;
    m_sample = o;
    if (o) begin
      m_out = m_prev + floor_div((m_cur - m_prev) * (m_phase + 1), RATE);
      if (m_phase < RATE - 1) m_phase++;
    end
    if (c) begin
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      m_prev = m_cur; m_cur = narrow_m(sum); m_clip = sat_m(sum); m_phase = 0;
    end
    if (s) begin
      if (c) begin m_q.delete(); m_q.push_back(din); end
      else if (m_q.size() < VOICES) m_q.push_back(din);
      else m_err = 1;
    end
  endtask

  typedef struct {
    bit c, s, o;
    int din;
    int eo;
    bit es;
  } vec_t;

  vec_t tbl[22];
  int exp_v;

  initial begin
    tbl[0]  = '{1, 1, 0,  100,     0, 0};
    tbl[1]  = '{0, 1, 0,  200,     0, 0};
    tbl[2]  = '{0, 1, 0,  300,     0, 0};
    tbl[3]  = '{0, 1, 0,  400,     0, 0};
    tbl[4]  = '{1, 1, 1, -250,     0, 1};
    tbl[5]  = '{0, 0, 1,    0,   250, 1};
    tbl[6]  = '{0, 1, 0, -250,   250, 0};
    tbl[7]  = '{0, 1, 1, -250,   500, 1};
    tbl[8]  = '{0, 1, 1, -250,   750, 1};
    tbl[9]  = '{1, 1, 1,    0,  1000, 1};
    tbl[10] = '{0, 0, 1,    0,   500, 1};
    tbl[11] = '{0, 0, 1,    0,     0, 1};
    tbl[12] = '{0, 0, 1,    0,  -500, 1};
    tbl[13] = '{1, 1, 1,  400, -1000, 1};
    tbl[14] = '{1, 1, 0,    0, -1000, 0};
    tbl[15] = '{0, 0, 1,    0,   100, 1};
    tbl[16] = '{0, 0, 1,    0,   200, 1};
    tbl[17] = '{0, 0, 1,    0,   300, 1};
    tbl[18] = '{0, 0, 1,    0,   400, 1};
    tbl[19] = '{0, 0, 1,    0,   400, 1};
    tbl[20] = '{0, 0, 1,    0,   400, 1};
    tbl[21] = '{0, 0, 0,    0,   400, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", int'(sound_out), 0);
    check("reset_flags", {sample, clip, slot_err}, 0);
    rst = 0;

    // Sum, positive and negative slopes, extra output strobes
    foreach (tbl[i]) begin
      cyc(tbl[i].c, tbl[i].s, tbl[i].o, tbl[i].din);
      check($sformatf("tbl%0d_out", i), int'(sound_out), tbl[i].eo);
      check($sformatf("tbl%0d_sample", i), int'(sample), int'(tbl[i].es));
    end

    // Positive saturation / wrap
    cyc(1, 1, 0, 2047);
    repeat (7) cyc(0, 1, 0, 2047);
    cyc(1, 0, 0, 0);
`ifdef JT6295_ACCMIX_SAT_EN
    check("sat_pos_clip", int'(clip), 1);
    exp_v = 8191;
`else
    check("sat_pos_clip", int'(clip), 0);
    exp_v = -8;
`endif
    repeat (4) cyc(0, 0, 1, 0);
    check("sat_pos_cur", int'(sound_out), exp_v);

    // Negative saturation / wrap
    cyc(1, 1, 0, -2048);
    repeat (7) cyc(0, 1, 0, -2048);
    cyc(1, 0, 0, 0);
`ifdef JT6295_ACCMIX_SAT_EN
    check("sat_neg_clip", int'(clip), 1);
    exp_v = -8192;
`else
    check("sat_neg_clip", int'(clip), 0);
    exp_v = 0;
`endif
    repeat (4) cyc(0, 0, 1, 0);
    check("sat_neg_cur", int'(sound_out), exp_v);

    // Slot overflow, sticky error
    cyc(1, 1, 0, 1);
    repeat (7) cyc(0, 1, 0, 1);
    check("ovf_err_pre", int'(slot_err), 0);
    cyc(0, 1, 0, 1);
    check("ovf_err_set", int'(slot_err), 1);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    check("ovf_cur", int'(sound_out), 8);
    cyc(1, 1, 0, 5);
    repeat (2) cyc(0, 1, 0, 5);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    check("ovf_clean_cur", int'(sound_out), 15);
    check("ovf_err_sticky", int'(slot_err), 1);

    // Reset mid-frame, asserted between clock edges
    cyc(1, 1, 0, 500);
    cyc(0, 1, 1, 500);
    cyc(0, 1, 0, 500);
    #2 rst = 1;
    #1;
    check("rst_mid_out", int'(sound_out), 0);
    check("rst_mid_flags", {sample, clip, slot_err}, 0);
    @(posedge clk); #1 rst = 0;
    cyc(1, 1, 0, 10);
    repeat (3) cyc(0, 1, 0, 10);
    cyc(1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 0);
      check($sformatf("rst_after_out%0d", k), int'(sound_out), 10 * k);
    end

    // Randomized strobes against the reference model
    rst = 1; @(posedge clk); #1 rst = 0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      bit rc, rs, ro;
      int rd;
      rc = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 1) == 1);
      ro = ($urandom_range(0, 3) == 0);
      rd = int'($urandom_range(0, 4095)) - 2048;
      cyc(rc, rs, ro, rd);
      model_step(rc, rs, ro, rd);
      check("rnd_out", int'(sound_out), m_out);
      check("rnd_flags", {sample, clip, slot_err}, {m_sample, m_clip, m_err});
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
